mem_store_buffer: RTL

- Memory-stage load/store unit sitting directly upstream of the data memory.
- Accepts one load or store per cycle from the pipeline memory stage over a valid/ready handshake.
- Queues stores in a small FIFO and drains them to the data memory port; services loads either from memory or by forwarding from buffered stores.
- Guarantees the data memory never sees read and write asserted together.

---
 rtl/mem_store_buffer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - memory-stage store buffer with load forwarding and a single serialized data-memory port
// Stores queue in a small FIFO and drain one per idle cycle; loads forward from the buffer or take one memory read cycle.
module mem_store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic [ADDR_W-1:0]        mem_address,
   output logic [DATA_W-1:0]        mem_writeData,
   output logic                     mem_read,
   output logic                     mem_write,
   input  logic [DATA_W-1:0]        mem_readData,
   output logic                     sb_empty,
   output logic [$clog2(DEPTH):0]   sb_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_addr [DEPTH];
   logic [DATA_W-1:0]   r_data [DEPTH];
   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [CNT_W-1:0]    r_count;
   logic [ADDR_W-1:0]   r_ld_addr;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;

   logic                w_accept;
   logic                w_st_acc;
   logic                w_ld_acc;
   logic                w_ld_hit;
   logic                w_ld_miss;
   logic                w_drain;
   logic                w_hit;
   logic [DATA_W-1:0]   w_hit_data;
   logic [PTR_W-1:0]    w_idx;

   assign req_ready = (r_state == ST_IDLE) && (r_count < CNT_W'(DEPTH));
   assign w_accept  = req_valid && req_ready;
   assign w_st_acc  = w_accept && req_write;
   assign w_ld_acc  = w_accept && !req_write;
   assign w_ld_hit  = w_ld_acc && w_hit;
   assign w_ld_miss = w_ld_acc && !w_hit;
   assign w_drain   = (r_state == ST_IDLE) && (r_count != '0);

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign sb_empty  = (r_count == '0);
   assign sb_count  = r_count;

   // Walk entries oldest to youngest so the last match left standing is the youngest store.
   // The head is still searched while it drains, so its data is never lost to a load.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      w_idx      = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PTR_W'(i);
         if ((CNT_W'(i) < r_count) && (r_addr[w_idx] == req_addr)) begin
            w_hit      = 1'b1;
            w_hit_data = r_data[w_idx];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_ld_miss) w_state_nxt = ST_LOAD;
         ST_LOAD: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The load owns the port in LOAD; otherwise the head store drains. The port is zeroed when unused.
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writeData = '0;
      if (r_state == ST_LOAD) begin
         mem_read    = 1'b1;
         mem_address = r_ld_addr;
      end else if (w_drain) begin
         mem_write     = 1'b1;
         mem_address   = r_addr[r_head];
         mem_writeData = r_data[r_head];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_ld_addr   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_st_acc) r_tail <= r_tail + PTR_W'(1);
         if (w_drain)  r_head <= r_head + PTR_W'(1);
         case ({w_st_acc, w_drain})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         r_rsp_valid <= w_ld_hit || (r_state == ST_LOAD);
         if (r_state == ST_LOAD) begin
            r_rsp_rdata <= mem_readData;
         end else if (w_ld_hit) begin
            r_rsp_rdata <= w_hit_data;
         end
         if (w_ld_miss) r_ld_addr <= req_addr;
      end
   end

   // Entry storage needs no reset: occupancy is tracked solely by r_count.
   always_ff @(posedge clk) begin
      if (w_st_acc) begin
         r_addr[r_tail] <= req_addr;
         r_data[r_tail] <= req_wdata;
      end
   end

endmodule
